fir_inverse_threefold: RTL and testbench

Three-fold folded all-zero (FIR) inverse of the team's third-order all-pole IIR section. It recovers the excitation sample stream x from a filtered stream y, and sits at the receive end of the filter chain. One multiplier and one subtractor are time-shared over a 3-cycle schedule, so the block accepts one sample every 3 clocks. Arithmetic is 20-bit signed Q10.10: 10 integer bits and 10 fractional bits.

---
 rtl/fixed_q10_pkg.sv | 22 ++
 rtl/mul_q10.sv | 23 ++
 rtl/fir_inverse_threefold.sv | 134 +++++++++++++
 tb/tb_fir_inverse_threefold.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_q10_pkg.sv
// Shared Q10.10 fixed-point definitions for the third-order IIR section and
// its FIR inverse: word format, default coefficients and the folded schedule.
package fixed_q10_pkg;

  localparam int Q_WIDTH = 20;
  localparam int Q_FRAC  = 10;

  localparam logic [Q_WIDTH-1:0] Q_ONE = 20'h00400;

  // Default section coefficients: 2.0, 4.0 and 8.0 in Q10.10.
  localparam logic [Q_WIDTH-1:0] A1_DEFAULT = 20'h00800;
  localparam logic [Q_WIDTH-1:0] A2_DEFAULT = 20'h01000;
  localparam logic [Q_WIDTH-1:0] A3_DEFAULT = 20'h02000;

  // Three-step schedule of the folded datapath.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC2 = 2'd1,
    MAC3 = 2'd2
  } fir_state_e;

endpackage

// File: rtl/mul_q10.sv
// Combinational Q10.10 signed multiply: full 40-bit product, arithmetic shift
// right by the fraction width (floor), low word kept with two's-complement wrap.
module mul_q10
  import fixed_q10_pkg::*;
(
  input  logic [Q_WIDTH-1:0] a,
  input  logic [Q_WIDTH-1:0] b,
  output logic [Q_WIDTH-1:0] p
);

  logic signed [2*Q_WIDTH-1:0] full;
  logic                        unused_bits;

  // Bits [29:10] of the full product equal (product >>> 10) truncated to 20 bits.
  always_comb begin
    full = $signed(a) * $signed(b);
    p    = full[Q_FRAC +: Q_WIDTH];
  end

  // Guard and discarded fraction bits are intentionally dropped (wrap + floor).
  assign unused_bits = ^{full[2*Q_WIDTH-1:Q_FRAC+Q_WIDTH], full[Q_FRAC-1:0]};

endmodule

// File: rtl/fir_inverse_threefold.sv
// Three-fold folded FIR inverse of the third-order all-pole section:
//   x[n] = y[n] - A1*y[n-1] - A2*y[n-2] - A3*y[n-3]
// One multiplier and one subtractor are shared over IDLE/MAC2/MAC3, so one
// sample is accepted every three clocks.
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is high only in IDLE with rst_n high; in_valid is
// ignored otherwise and nothing is buffered, so the source holds y_in and
// in_valid until the transfer. out_valid is a one-cycle pulse two edges after
// the accepting edge; x_out holds its value between pulses.
module fir_inverse_threefold
  import fixed_q10_pkg::*;
#(
  parameter logic [19:0] A1 = A1_DEFAULT,
  parameter logic [19:0] A2 = A2_DEFAULT,
  parameter logic [19:0] A3 = A3_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [19:0] x_out,
  output logic        out_valid
);

  fir_state_e  state;
  fir_state_e  state_next;

  logic [19:0] h1;
  logic [19:0] h2;
  logic [19:0] h3;
  logic [19:0] ycur;
  logic [19:0] acc;

  logic [19:0] coef;
  logic [19:0] hist;
  logic [19:0] minuend;
  logic [19:0] prod;
  logic [19:0] diff;
  logic        accept;

  // State register; reset abandons any sample in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: wait for a transfer in IDLE, then walk the two MAC steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC2;
      MAC2:    state_next = MAC3;
      MAC3:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and datapath steering: coefficient/history/minuend chosen by state.
  always_comb begin
    in_ready = rst_n && (state == IDLE);
    accept   = in_valid && in_ready;
    coef     = A1;
    hist     = h1;
    minuend  = y_in;
    case (state)
      MAC2: begin
        coef    = A2;
        hist    = h2;
        minuend = acc;
      end
      MAC3: begin
        coef    = A3;
        hist    = h3;
        minuend = acc;
      end
      default: begin
        coef    = A1;
        hist    = h1;
        minuend = y_in;
      end
    endcase
  end

  mul_q10 u_mul (
    .a (coef),
    .b (hist),
    .p (prod)
  );

  // Single shared subtractor, 20-bit wrap.
  assign diff = minuend - prod;

  // Datapath registers: accumulate, publish the result, shift the history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h1        <= '0;
      h2        <= '0;
      h3        <= '0;
      ycur      <= '0;
      acc       <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc  <= diff;
            ycur <= y_in;
          end
        end
        MAC2: begin
          acc <= diff;
        end
        MAC3: begin
          x_out     <= diff;
          out_valid <= 1'b1;
          h3        <= h2;
          h2        <= h1;
          h1        <= ycur;
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_inverse_threefold.sv
// Bench for fir_inverse_threefold: directed impulse, round-trip, handshake,
// wrap, truncation and mid-operation reset cases, then a random stream.
module tb_fir_inverse_threefold;
  import fixed_q10_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Instance a: default coefficients. Instance b: A1 = 0.5.
  logic [19:0] y_a, y_b;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic [19:0] x_a, x_b;
  logic        ov_a, ov_b;

  fir_inverse_threefold dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .x_out     (x_a),
    .out_valid (ov_a)
  );

  fir_inverse_threefold #(.A1(20'h00200)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .x_out     (x_b),
    .out_valid (ov_b)
  );

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q_a[$];
  logic [19:0] exp_q_b[$];
  int          tests_run = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference for the random stream, using integer arithmetic on wide values.
  function automatic logic [19:0] model_x(input logic [19:0] y, input logic [19:0] m1,
                                          input logic [19:0] m2, input logic [19:0] m3);
    longint s;
    s = longint'($signed(y))
        - ((longint'($signed(A1_DEFAULT)) * longint'($signed(m1))) >>> 10)
        - ((longint'($signed(A2_DEFAULT)) * longint'($signed(m2))) >>> 10)
        - ((longint'($signed(A3_DEFAULT)) * longint'($signed(m3))) >>> 10);
    return s[19:0];
  endfunction

  // Output monitors: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      if (exp_q_a.size() == 0) check("a_spurious_out_valid", 20'd1, 20'd0);
      else check("a_x_out", x_a, exp_q_a.pop_front());
    end
    if (ov_b === 1'b1) begin
      if (exp_q_b.size() == 0) check("b_spurious_out_valid", 20'd1, 20'd0);
      else check("b_x_out", x_b, exp_q_b.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one sample, wait for its transfer, then check the ready/valid
  // pattern over the following three cycles. hold keeps in_valid high so the
  // next call transfers back-to-back.
  task automatic send(input bit sel, input logic [19:0] y, input logic [19:0] exp,
                      input bit hold);
    int waited;
    waited = 0;
    if (sel) begin
      y_b = y; in_valid_b = 1'b1; exp_q_b.push_back(exp);
    end else begin
      y_a = y; in_valid_a = 1'b1; exp_q_a.push_back(exp);
    end
    while (!(sel ? in_ready_b : in_ready_a)) begin
      if (waited >= 30) begin
        check("accept_timeout", 20'd0, 20'd1);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    end
    @(negedge clk);
    check("ready_low_mac2", {19'd0, sel ? in_ready_b : in_ready_a}, 20'd0);
    check("out_valid_early1", {19'd0, sel ? ov_b : ov_a}, 20'd0);
    @(negedge clk);
    check("ready_low_mac3", {19'd0, sel ? in_ready_b : in_ready_a}, 20'd0);
    check("out_valid_early2", {19'd0, sel ? ov_b : ov_a}, 20'd0);
    @(negedge clk);
    check("ready_high_idle", {19'd0, sel ? in_ready_b : in_ready_a}, 20'd1);
    check("out_valid_latency", {19'd0, sel ? ov_b : ov_a}, 20'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [19:0] r_y, r_exp, m1, m2, m3;

  initial begin
    rst_n      = 1'b0;
    y_a        = '0;
    y_b        = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_x_out_a", x_a, 20'h00000);
    check("rst_out_valid_a", {19'd0, ov_a}, 20'd0);
    check("rst_in_ready_a", {19'd0, in_ready_a}, 20'd0);
    check("rst_in_ready_b", {19'd0, in_ready_b}, 20'd0);
    check("rst_x_out_b", x_b, 20'h00000);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready_a", {19'd0, in_ready_a}, 20'd1);
    check("post_rst_ready_b", {19'd0, in_ready_b}, 20'd1);

    // Impulse
    send(1'b0, 20'h00400, 20'h00400, 1'b0);
    send(1'b0, 20'h00000, 20'hFF800, 1'b0);
    send(1'b0, 20'h00000, 20'hFF000, 1'b0);
    send(1'b0, 20'h00000, 20'hFE000, 1'b0);
    send(1'b0, 20'h00000, 20'h00000, 1'b0);

    // Round trip, in_valid held continuously (back-to-back handshake)
    send(1'b0, 20'h00400, 20'h00400, 1'b1);
    send(1'b0, 20'h00800, 20'h00000, 1'b1);
    send(1'b0, 20'h02000, 20'h00000, 1'b1);
    send(1'b0, 20'h08000, 20'h00000, 1'b0);
    repeat (4) @(negedge clk);
    check("x_out_holds", x_a, 20'h00000);

    // Wrap
    do_reset();
    send(1'b0, 20'h7FC00, 20'h7FC00, 1'b0);
    send(1'b0, 20'h00000, 20'h00800, 1'b0);

    // Truncation with A1 = 0.5
    send(1'b1, 20'hFFFFF, 20'hFFFFF, 1'b0);
    send(1'b1, 20'h00000, 20'h00001, 1'b0);
    do_reset();
    send(1'b1, 20'h00001, 20'h00001, 1'b0);
    send(1'b1, 20'h00000, 20'h00000, 1'b0);

    // Reset mid-operation: history is non-zero, x_out holds 0x00800 from before
    do_reset();
    send(1'b0, 20'h7FC00, 20'h7FC00, 1'b0);
    send(1'b0, 20'h00000, 20'h00800, 1'b0);
    @(negedge clk);
    y_a = 20'h00400;
    in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {19'd0, ov_a}, 20'd0);
    check("midrst_x_out", x_a, 20'h00000);
    check("midrst_in_ready", {19'd0, in_ready_a}, 20'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_x_out_after", x_a, 20'h00000);
    send(1'b0, 20'h00400, 20'h00400, 1'b0);
    send(1'b0, 20'h00000, 20'hFF800, 1'b0);
    send(1'b0, 20'h00000, 20'hFF000, 1'b0);
    send(1'b0, 20'h00000, 20'hFE000, 1'b0);
    send(1'b0, 20'h00000, 20'h00000, 1'b0);

    // Random stream against the reference
    do_reset();
    m1 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < 20; i++) begin
      r_y   = 20'($urandom_range(0, 20'hFFFFF));
      r_exp = model_x(r_y, m1, m2, m3);
      send(1'b0, r_y, r_exp, (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0);
      m3 = m2; m2 = m1; m1 = r_y;
    end

    repeat (6) @(negedge clk);
    check("a_queue_drained", 20'(exp_q_a.size()), 20'd0);
    check("b_queue_drained", 20'(exp_q_b.size()), 20'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
